// File: rtl/alu_rr_arbiter_pkg.sv
// Shared constants for the round-robin front end of the status-flag ALU.
package alu_rr_arbiter_pkg;
    localparam int ALU_W = 5;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;
endpackage

// File: rtl/alu_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid bit at or after ptr, wrapping.
module rr_picker #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            any
);
    int j;

    // Scan from the far end back toward ptr so the nearest candidate wins last.
    always_comb begin
        j     = 0;
        idx   = '0;
        grant = '0;
        any   = |valid;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (valid[j]) idx = PW'(j);
        end
        if (any) grant[idx] = 1'b1;
    end
endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end that time-shares one registered-operand ALU among NREQ requesters.
module alu_rr_arbiter
    import alu_rr_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int W    = ALU_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*2-1:0] req_op,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [W-1:0]      resp_result,
    output logic              resp_carry,
    output logic              resp_zero,
    output logic              resp_negative,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [1:0]        alu_op,
    input  logic [W-1:0]      alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic              alu_negative,
    output logic              busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [1:0]      state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gidx;
    logic            gany;

    rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    // rst_n gates the ready pulse so nothing looks accepted while held in reset.
    assign req_ready = (state == IDLE && rst_n) ? grant : '0;
    assign busy      = (state != IDLE);

    always_comb begin
        resp_valid = '0;
        if (state == RESP) resp_valid[owner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            owner         <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_op        <= '0;
            resp_result   <= '0;
            resp_carry    <= 1'b0;
            resp_zero     <= 1'b0;
            resp_negative <= 1'b0;
        end else begin
            case (state)
                IDLE: if (gany) begin
                    alu_a  <= req_a[int'(gidx)*W +: W];
                    alu_b  <= req_b[int'(gidx)*W +: W];
                    alu_op <= req_op[int'(gidx)*2 +: 2];
                    owner  <= gidx;
                    state  <= ISSUE;
                end
                ISSUE: begin
                    resp_result   <= alu_result;
                    resp_carry    <= alu_carry;
                    resp_zero     <= alu_zero;
                    resp_negative <= alu_negative;
                    state         <= RESP;
                end
                RESP: if (resp_ready[owner]) begin
                    // Pointer moves only on completion so idle cycles never skip anyone.
                    ptr   <= PW'((int'(owner) + 1) % NREQ);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational 5-bit status-flag ALU (a, b, op -> result, carry, zero, negative) among NREQ requesters in the vending-machine datapath, e.g. coin accumulator, price comparator and change calculator.
- Round-robin arbitration with valid/ready request and response handshakes.
- Registers the ALU operands and captures the result and flags, so requesters never see ALU glitches.
- The ALU is instantiated beside this block; this block drives its inputs and samples its outputs.

Parameters:
- NREQ, 3, number of requesters (2..4).
- W, 5, operand/result width; must match the ALU.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept pulse; handshake = valid & ready.
- req_a  in  NREQ*W  packed operand A; requester i uses bits [i*W +: W].
- req_b  in  NREQ*W  packed operand B, same packing.
- req_op  in  NREQ*2  packed opcode, passed to the ALU unchanged.
- resp_valid  out  NREQ  one-hot response valid to the owning requester.
- resp_ready  in  NREQ  per-requester response accept.
- resp_result  out  W  captured ALU result.
- resp_carry  out  1  captured carry flag.
- resp_zero  out  1  captured zero flag.
- resp_negative  out  1  captured negative flag.
- alu_a  out  W  registered operand to the ALU.
- alu_b  out  W  registered operand to the ALU.
- alu_op  out  2  registered opcode to the ALU.
- alu_result  in  W  ALU result.
- alu_carry  in  1  ALU carry flag.
- alu_zero  in  1  ALU zero flag.
- alu_negative  in  1  ALU negative flag.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ptr=0, owner=0, all outputs 0 (alu_a/b/op, resp_*, req_ready, resp_valid, busy).
- State machine IDLE -> ISSUE -> RESP -> IDLE.
- IDLE, arbitration:
  - If any req_valid bit is set, the winner is the first set bit scanning ptr, ptr+1, ... mod NREQ.
  - req_ready[winner]=1 combinationally in that cycle only.
  - At the clock edge: latch alu_a/alu_b/alu_op from the winner's slice, set owner=winner, go to ISSUE.
  - With no valid bit set: stay in IDLE; alu_* hold their last values.
- ISSUE (1 cycle):
  - ALU inputs are stable.
  - At the edge, capture alu_result/carry/zero/negative into resp_* and go to RESP.
- RESP:
  - resp_valid[owner]=1; all other resp_valid bits are 0; resp_* stay stable.
  - When resp_ready[owner]=1: clear resp_valid, set ptr=(owner+1) mod NREQ, go to IDLE.
  - resp_ready on non-owner bits is ignored.
- Latency and throughput:
  - Request accept to resp_valid: 2 cycles.
  - Minimum 3 cycles per operation.
  - No new request is accepted while busy.
- Simultaneous requests: serviced strictly round-robin; no requester waits more than NREQ-1 operations once its request is asserted.
- Requester rules:
  - A requester must hold req_valid and its operands until it sees req_ready.
  - Dropping req_valid before the handshake is legal; that request is simply never taken.
- Flags: no arithmetic in this block. Flags are exactly the ALU's values sampled at the end of ISSUE.
- Reset mid-operation: abort immediately, return to reset values, discard any pending response.
- Tie-free pointer: ptr advances only on response completion, never on idle cycles.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11;
  - state encoding IDLE/ISSUE/RESP;
  - ALU_W=5.
- One natural sub-module: rr_picker.
  - Combinational; inputs req_valid and ptr.
  - Outputs a one-hot grant and its index.
- The FSM and capture registers stay in alu_rr_arbiter.

Test Plan:
1. Single add: requester 0 sends a=5, b=3, op=ADD.
   - Required: req_ready[0] pulses for 1 cycle; 2 cycles later resp_valid=3'b001.
   - Response: result=8, zero=0, negative=0; cleared on resp_ready[0].
2. Zero flag: requester 1 sends 0+0.
   - Required: resp_valid=3'b010, result=0, zero=1.
3. Round robin: all three requesters assert together (ptr=0) with distinct operands.
   - Required: grant order 0, 1, 2; after that, requester 0 re-asserting while requester 2 is pending yields order 2, 0.
   - Each result matches its own operands.
4. Backpressure: hold resp_ready low 5 cycles while requester 2 is valid.
   - Required: resp_* stable, busy=1, req_ready[2] never asserts until the response completes.
5. Subtract/negative: requester 1 sends a=3, b=5, op=SUB.
   - Required: alu_a=3, alu_b=5, alu_op=01 during ISSUE.
   - Response: result=5'd30, negative=1, carry equal to the ALU's carry output.
6. Reset mid-op: drop rst_n during RESP.
   - Required: all outputs 0 immediately and ptr=0; a following request from requester 0 completes normally.
